pifo_dequeue_ctrl: RTL
======================

Name: pifo_dequeue_ctrl

Overview:
- Read-side companion to the dual-push flow-scheduler PIFO.
- Owns the PIFO `pop` pin and matches each pop to its one-cycle-later `pop_valid`/`pop_value`/`pop_flow` response.
- Buffers granted entries in a small output FIFO and hands them to the downstream transmit/egress stage over a valid/ready interface.
- Uses credit accounting and empty-backoff so it never overruns its buffer or spins on an empty PIFO.

Parameters:
- FLOWS, 10, flow bitmask width; matches the PIFO.
- OBUF_DEPTH, 4, output FIFO entries; power of two, ≥2.
- BACKOFF_CYCLES, 4, idle cycles after an empty pop return; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  permit new pops
- pifo_pop  out  1  pop request to PIFO
- pifo_pop_value  in  32  PIFO head value, sampled cycle after pop
- pifo_pop_flow  in  FLOWS  PIFO head flow mask
- pifo_pop_valid  in  1  PIFO response valid
- m_valid  out  1  downstream entry valid
- m_ready  in  1  downstream accept
- m_value  out  32  entry value
- m_flow  out  FLOWS  entry flow mask
- empty_pops  out  16  saturating count of pops returned empty
- proto_err  out  1  sticky; response with no pop in flight

Behaviour:
- Reset (clk, rst: synchronous, active-high):
  - Outputs: pifo_pop=0, m_valid=0, m_value=0, m_flow=0, empty_pops=0, proto_err=0.
  - Internal: FIFO empty, inflight=0, state=IDLE, backoff counter=0.
- Response latency:
  - A pop asserted in cycle t is answered in cycle t+1 only.
  - inflight is a 1-bit register equal to pifo_pop of the previous cycle.
- Capture: inflight && pifo_pop_valid pushes {value, flow} into the FIFO in the same edge.
- Empty return: inflight && !pifo_pop_valid.
  - No push into the FIFO.
  - empty_pops increments, saturating at 0xFFFF.
- Protocol error: pifo_pop_valid && !inflight sets proto_err. The data is discarded. Only rst clears proto_err.
- Credit rule: reserved = occupancy + inflight. A pop may issue only when reserved − (m_valid && m_ready) < OBUF_DEPTH, i.e. a same-cycle downstream drain frees a credit.
- State machine:
  - IDLE: pifo_pop=0. Go to ISSUE when enable=1.
  - ISSUE:
    - pifo_pop = credit_ok && !empty_return.
    - Back-to-back pops every cycle are legal.
    - On empty_return: go to BACKOFF and load the counter with BACKOFF_CYCLES−1. The pop is suppressed in that same cycle.
    - On enable=0: go to IDLE. Any outstanding inflight response is still captured.
  - BACKOFF:
    - pifo_pop=0; the counter decrements.
    - At 0, go to ISSUE if enable=1, else IDLE.
    - A late response from an earlier pop is still captured.
- Output FIFO:
  - First-word-fall-through; m_valid = !fifo_empty.
  - m_value/m_flow hold stable while m_valid && !m_ready.
  - Simultaneous push and pop allowed at any occupancy, including full (credit guarantees push-when-full cannot occur without a same-cycle pop).
  - Pointers are log2(OBUF_DEPTH) bits and wrap naturally; occupancy counter is log2(OBUF_DEPTH)+1 bits.
- Reset mid-operation: an in-flight response arriving in the cycle after rst deasserts is ignored (inflight was cleared). It does not set proto_err, because the PIFO also clears its pop_valid_S on rst.

Optional Feature:
- Macro: PIFO_DEQ_FLOW_STATS_EN.
- Defined:
  - Adds input stat_sel [$clog2(FLOWS)-1:0] and output stat_count [15:0].
  - One 16-bit saturating counter per flow bit, incremented on each downstream handshake (m_valid && m_ready) whose m_flow bit is set.
  - stat_count = counter[stat_sel], registered, 1-cycle latency. Counters are 0 at reset.
- Undefined: no extra ports, no counters.

Decomposition:
- pifo_pkg: VALUE_W=32, typedef deq_state_e {IDLE, ISSUE, BACKOFF}, typedef struct entry_t {value, flow} parameterized through localparam FLOWS.
- One sub-module: pifo_obuf (FWFT FIFO of entry_t, DEPTH parameter, push/pop/occupancy).
- Credit logic and FSM stay in the top.

Test Plan:
- Basic: enable=1, PIFO model holds values 10,20,30 (flows 0x001,0x002,0x004), m_ready=1 → pops in cycles 1-3; m_value 10,20,30 in order, each the cycle after its capture; m_flow matches.
- Backpressure: m_ready=0, PIFO holds 8 entries, OBUF_DEPTH=4 → exactly 4 pops issued, then pifo_pop=0. Raise m_ready → one pop per drained entry, none lost or duplicated.
- Empty: PIFO empty → one pop, empty return, then 4 cycles pifo_pop=0, then retry. empty_pops increments by 1 per returned-empty pop.
- Back-to-back into empty: PIFO holds 1 entry, two consecutive pops → first captured, second empty; BACKOFF entered, empty_pops=1.
- Reset mid-flight: rst asserted in the cycle after a pop, model returns valid data → no FIFO entry, proto_err=0, all outputs at reset values.
- (PIFO_DEQ_FLOW_STATS_EN) Drain 3 entries of flow 0x004 and 1 of 0x001 → stat_sel=2 reads 3, stat_sel=0 reads 1.

Source files
------------

// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared types for the PIFO dequeue controller
package pifo_pkg;

    localparam int VALUE_W = 32;
    localparam int FLOWS   = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        BACKOFF = 2'd2
    } deq_state_e;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [FLOWS-1:0]   flow;
    } entry_t;

endpackage

// File: rtl/pifo_obuf.sv
// rtl/pifo_obuf.sv - first-word-fall-through output FIFO of PIFO entries
module pifo_obuf
    import pifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  entry_t                   i_push_data,
    input  logic                     i_pop,
    output entry_t                   o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int PW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic            w_do_pop;

    assign w_do_pop    = i_pop && (r_count != '0);
    assign o_valid     = (r_count != '0);
    assign o_occupancy = r_count;
    // Head is forced to zero while empty so the outputs read zero out of reset.
    assign o_head      = o_valid ? r_mem[r_rd_ptr] : '0;

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop including simultaneous ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/pifo_dequeue_ctrl.sv
// rtl/pifo_dequeue_ctrl.sv - PIFO pop issuer with credit/backoff control (optional PIFO_DEQ_FLOW_STATS_EN)
module pifo_dequeue_ctrl
    import pifo_pkg::*;
#(
    parameter int FLOWS          = pifo_pkg::FLOWS,
    parameter int OBUF_DEPTH     = 4,
    parameter int BACKOFF_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic                      pifo_pop,
    input  logic [VALUE_W-1:0]        pifo_pop_value,
    input  logic [FLOWS-1:0]          pifo_pop_flow,
    input  logic                      pifo_pop_valid,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [VALUE_W-1:0]        m_value,
    output logic [FLOWS-1:0]          m_flow,
    output logic [15:0]               empty_pops,
    output logic                      proto_err
`ifdef PIFO_DEQ_FLOW_STATS_EN
    ,
    input  logic [$clog2(FLOWS)-1:0]  stat_sel,
    output logic [15:0]               stat_count
`endif
);

    localparam int OW = $clog2(OBUF_DEPTH) + 1;
    localparam int CW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [CW-1:0] BACKOFF_LOAD = CW'(BACKOFF_CYCLES - 1);
    localparam logic [OW:0]   DEPTH_LIM    = (OW+1)'(OBUF_DEPTH);

    deq_state_e      r_state;
    deq_state_e      w_next_state;
    logic            r_inflight;
    logic [CW-1:0]   r_backoff_cnt;
    logic [15:0]     r_empty_pops;
    logic            r_proto_err;

    logic [OW-1:0]   w_occ;
    logic [OW:0]     w_reserved;
    logic            w_drain;
    logic            w_credit_ok;
    logic            w_capture;
    logic            w_empty_ret;
    logic            w_spurious;
    entry_t          w_push_data;
    entry_t          w_head;

    assign w_capture   = r_inflight && pifo_pop_valid;
    assign w_empty_ret = r_inflight && !pifo_pop_valid;
    assign w_spurious  = pifo_pop_valid && !r_inflight;
    assign w_drain     = m_valid && m_ready;
    // Outstanding pop counts against the buffer; a same-cycle drain frees one slot.
    assign w_reserved  = {1'b0, w_occ} + {{OW{1'b0}}, r_inflight};
    assign w_credit_ok = (w_reserved - {{OW{1'b0}}, w_drain}) < DEPTH_LIM;

    assign w_push_data = '{value: pifo_pop_value, flow: pifo_pop_flow};
    assign m_value     = w_head.value;
    assign m_flow      = w_head.flow;
    assign empty_pops  = r_empty_pops;
    assign proto_err   = r_proto_err;

    pifo_obuf #(.DEPTH(OBUF_DEPTH)) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_capture),
        .i_push_data (w_push_data),
        .i_pop       (m_ready),
        .o_head      (w_head),
        .o_valid     (m_valid),
        .o_occupancy (w_occ)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: empty return wins over enable drop so the PIFO is not re-polled early.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (enable) w_next_state = ISSUE;
            end
            ISSUE: begin
                if (w_empty_ret)  w_next_state = BACKOFF;
                else if (!enable) w_next_state = IDLE;
            end
            BACKOFF: begin
                if (r_backoff_cnt == '0) w_next_state = enable ? ISSUE : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Pop output: only in ISSUE, with credit, and never in the cycle an empty return lands.
    always_comb begin
        pifo_pop = 1'b0;
        if (r_state == ISSUE) begin
            pifo_pop = enable && w_credit_ok && !w_empty_ret;
        end
    end

    // Backoff counter: loaded on entry, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_backoff_cnt <= '0;
        end else if (r_state == ISSUE && w_empty_ret) begin
            r_backoff_cnt <= BACKOFF_LOAD;
        end else if (r_state == BACKOFF && r_backoff_cnt != '0) begin
            r_backoff_cnt <= r_backoff_cnt - 1'b1;
        end
    end

    // Response tracking: inflight mirrors last cycle's pop; empty and stray responses are logged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight   <= 1'b0;
            r_empty_pops <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_inflight <= pifo_pop;
            if (w_empty_ret && r_empty_pops != 16'hFFFF) begin
                r_empty_pops <= r_empty_pops + 16'd1;
            end
            if (w_spurious) begin
                r_proto_err <= 1'b1;
            end
        end
    end

`ifdef PIFO_DEQ_FLOW_STATS_EN
    logic [15:0] r_flow_cnt [FLOWS];
    logic [15:0] r_stat_count;

    assign stat_count = r_stat_count;

    // Per-flow saturating handshake counters plus a registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLOWS; i++) begin
                r_flow_cnt[i] <= '0;
            end
            r_stat_count <= '0;
        end else begin
            for (int i = 0; i < FLOWS; i++) begin
                if (w_drain && m_flow[i] && r_flow_cnt[i] != 16'hFFFF) begin
                    r_flow_cnt[i] <= r_flow_cnt[i] + 16'd1;
                end
            end
            if (int'(stat_sel) < FLOWS) begin
                r_stat_count <= r_flow_cnt[stat_sel];
            end else begin
                r_stat_count <= '0;
            end
        end
    end
`endif

endmodule
